// File: rtl/seq_gen_0110_tx.sv
// seq_gen_0110_tx: serial pattern transmitter feeding a 0110 sequence detector.
// Latches a PAT_W-bit pattern and a repeat count, then shifts the pattern out
// MSB first, one bit per falling edge of KEY[3], (count+1) times.
// Optional build macro: SEQ_GEN_GAP_EN. When defined, one IDLE_LVL gap bit is
// inserted between consecutive frames. When undefined, frames go back-to-back
// and the GAP state does not exist.
// LEDR = {rem, done, busy, valid, serial}. All outputs are registered.
module seq_gen_0110_tx #(
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic [3:3]       KEY,
  input  logic [17:0]      SW,
  output logic [CNT_W+3:0] LEDR
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
`ifdef SEQ_GEN_GAP_EN
    S_GAP   = 3'd2,
`endif
    S_DONE  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // Board wiring: push-button clock (falling edge), reset switch, start switch.
  logic             w_clk;
  logic             w_rst_n;
  logic             w_start;
  logic [PAT_W-1:0] w_sw_pat;
  logic [CNT_W-1:0] w_sw_cnt;
  logic             w_unused_sw;

  assign w_clk       = KEY[3];
  assign w_rst_n     = SW[1];
  assign w_start     = SW[0];
  assign w_sw_pat    = SW[17 -: PAT_W];
  assign w_sw_cnt    = SW[13 -: CNT_W];
  // Switches SW[9:2] have no function in this block.
  assign w_unused_sw = ^SW;

  state_t           r_state, w_state_nx;
  logic [PAT_W-1:0] r_pat,   w_pat_nx;
  logic [IDX_W-1:0] r_idx,   w_idx_nx;
  logic [CNT_W-1:0] r_rem,   w_rem_nx;
  logic             r_sdo,   w_sdo_nx;
  logic             r_vld,   w_vld_nx;
  logic             r_busy,  w_busy_nx;
  logic             r_done,  w_done_nx;

  // Next-state logic; outputs are derived from the next state so that each
  // registered output matches the state entered on the same edge.
  always_comb begin
    w_state_nx = r_state;
    w_pat_nx   = r_pat;
    w_idx_nx   = r_idx;
    w_rem_nx   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_pat_nx   = w_sw_pat;
          w_rem_nx   = w_sw_cnt;
          w_idx_nx   = IDX_MAX;
          w_state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_idx != '0) begin
          w_idx_nx = r_idx - IDX_W'(1);
        end else if (r_rem != '0) begin
          // Another frame follows; rem never goes below zero.
          w_rem_nx = r_rem - CNT_W'(1);
          w_idx_nx = IDX_MAX;
`ifdef SEQ_GEN_GAP_EN
          w_state_nx = S_GAP;
`else
          w_state_nx = S_SHIFT;
`endif
        end else begin
          w_state_nx = S_DONE;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      S_GAP:   w_state_nx = S_SHIFT;
`endif
      S_DONE:  w_state_nx = S_WAIT;
      // Start must be released before another transfer can begin.
      S_WAIT:  if (!w_start) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output decode from the state about to be entered.
  always_comb begin
    w_sdo_nx  = IDLE_LVL;
    w_vld_nx  = 1'b0;
    w_busy_nx = (w_state_nx != S_IDLE);
    w_done_nx = (w_state_nx == S_DONE);
    if (w_state_nx == S_SHIFT) begin
      w_sdo_nx = w_pat_nx[w_idx_nx];
      w_vld_nx = 1'b1;
    end
  end

  // State and output registers; reset is immediate, even mid-frame.
  always_ff @(negedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
      r_sdo   <= IDLE_LVL;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pat   <= w_pat_nx;
      r_idx   <= w_idx_nx;
      r_rem   <= w_rem_nx;
      r_sdo   <= w_sdo_nx;
      r_vld   <= w_vld_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign LEDR = {r_rem, r_done, r_busy, r_vld, r_sdo};

endmodule

// File: tb/tb_seq_gen_0110_tx.sv
// Bench for seq_gen_0110_tx: directed scenarios plus random traffic, checked
// against a transaction-level model that expands each accepted start request
// into the full list of expected LEDR words.
module tb_seq_gen_0110_tx;

  localparam int PAT_W = 4;
  localparam logic [7:0] L_IDLE = 8'h01;
  localparam logic [7:0] L_DONE = 8'h0D;
  localparam logic [7:0] L_WAIT = 8'h05;

  logic [3:3]  key;
  logic [17:0] sw;
  logic [7:0]  ledr;

  seq_gen_0110_tx dut (
    .KEY  (key),
    .SW   (sw),
    .LEDR (ledr)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         m_wait = 1'b0;
  logic [7:0] m_exp  = L_IDLE;
  logic [3:0] det_win = 4'hF;
  int         det_hits = 0;

  initial key = 1'b1;
  always #5 key = ~key;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expand one transfer into expected LEDR words: {rem, done, busy, vld, sdo}.
  task automatic build(input logic [3:0] p, input logic [3:0] c);
    logic [3:0] r;
    for (int f = 0; f <= int'(c); f++) begin
      r = 4'(int'(c) - f);
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({r, 3'b011, p[b]});
`ifdef SEQ_GEN_GAP_EN
      if (f < int'(c)) exp_q.push_back({4'(r - 4'd1), 4'b0101});
`endif
    end
    exp_q.push_back(L_DONE);
    exp_q.push_back(L_WAIT);
  endtask

  task automatic model_edge();
    if (!sw[1]) begin
      exp_q.delete(); m_wait = 1'b0; m_exp = L_IDLE;
    end else if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
    end else if (m_wait) begin
      if (!sw[0]) begin m_wait = 1'b0; m_exp = L_IDLE; end
      else m_exp = L_WAIT;
    end else if (sw[0]) begin
      build(sw[17:14], sw[13:10]);
      m_exp  = exp_q.pop_front();
      m_wait = 1'b1;
    end else begin
      m_exp = L_IDLE;
    end
  endtask

  // Drive after the rising edge, let the DUT act on the falling edge, then compare.
  task automatic step(input logic st, input logic [3:0] p, input logic [3:0] c, input string tag);
    sw[0]     = st;
    sw[17:14] = p;
    sw[13:10] = c;
    sw[9:2]   = 8'($urandom);
    @(negedge key[3]);
    model_edge();
    #2;
    chk(tag, 32'(ledr), 32'(m_exp));
    det_win = {det_win[2:0], ledr[0]};
    if (det_win == 4'b0110) det_hits++;
    @(posedge key[3]);
  endtask

  // Asynchronous reset mid-cycle: outputs must drop to idle without a clock edge.
  task automatic arst(input string tag);
    sw[1] = 1'b0;
    #1;
    exp_q.delete(); m_wait = 1'b0; m_exp = L_IDLE;
    chk(tag, 32'(ledr), 32'(L_IDLE));
    step(1'b1, 4'($urandom), 4'($urandom), "rst_hold");
    sw[1] = 1'b1;
  endtask

  initial begin
    sw = 18'h0;
    sw[17:14] = 4'hA;
    @(posedge key[3]);
    // Reset held with arbitrary switches.
    step(1'b1, 4'hF, 4'h7, "rst_a");
    step(1'b0, 4'h6, 4'h3, "rst_b");
    sw[1] = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 4'h6, 4'h0, "idle_hold");

    // Single frame, start for one edge only.
    step(1'b1, 4'h6, 4'h0, "single_b3");
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 4'h0, "single");
    // Single frame with start held: must park in release-wait.
    step(1'b1, 4'h6, 4'h0, "hold_b3");
    for (int i = 0; i < 8; i++) step(1'b1, 4'h6, 4'h0, "hold");
    step(1'b0, 4'h6, 4'h0, "hold_rel");
    step(1'b0, 4'h6, 4'h0, "hold_idle");

    // Repeat count 2.
    step(1'b1, 4'h6, 4'h2, "rep_start");
    for (int i = 0; i < 18; i++) step(1'b0, 4'h0, 4'h0, "rep");

    // Reset during the second bit, then restart from the MSB.
    step(1'b1, 4'h6, 4'h0, "mid_b3");
    step(1'b0, 4'h6, 4'h0, "mid_b2");
    arst("mid_arst");
    step(1'b0, 4'h6, 4'h0, "mid_idle");
    step(1'b1, 4'h6, 4'h0, "mid_restart");
    for (int i = 0; i < 7; i++) step(1'b0, 4'h6, 4'h0, "mid_tail");

    // Pattern and count switches change after the latch.
    step(1'b1, 4'h6, 4'h1, "latch_start");
    for (int i = 0; i < 12; i++) step(1'($urandom), 4'hF, 4'hF, "latch");
    step(1'b0, 4'hF, 4'hF, "latch_rel");
    step(1'b0, 4'hF, 4'hF, "latch_idle");

    // Loopback into a behavioural overlapping 0110 detector, count 1.
    det_win  = 4'hF;
    det_hits = 0;
    step(1'b1, 4'h6, 4'h1, "loop_start");
    for (int i = 0; i < 14; i++) step(1'b0, 4'h6, 4'h1, "loop");
    chk("loop_hits", 32'(det_hits), 32'd2);

    // Maximum count: 16 frames.
    step(1'b1, 4'h6, 4'hF, "max_start");
    for (int i = 0; i < 90; i++) step(1'b0, 4'h3, 4'h0, "max");

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) arst("rnd_arst");
      else step(1'($urandom_range(0, 3) == 0), 4'($urandom),
                ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
